uart_digit_tx: RTL
==================

Name: uart_digit_tx

Overview:
Transmit-side companion to the UART receive / seven-segment path. Accepts decimal digit values (0-9) over a valid/ready handshake and buffers them in a small FIFO. Sends each digit as its ASCII character on an 8N1 UART line, optionally followed by CR LF. Used to echo the displayed digit, or report board state, back to the host terminal.

Parameters:
BAUD_DIV, 1250, clocks per UART bit (12 MHz / 9600 baud); must be >= 2
FIFO_DEPTH, 4, digit buffer entries; power of two, >= 2
APPEND_CRLF, 1, 1 = send 0x0D then 0x0A after every digit character; 0 = digit character only

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
digit_in  input  4  digit value to send
digit_valid  input  1  digit_in valid this cycle
digit_ready  output  1  block can accept a digit this cycle
uarttx  output  1  UART serial output, idle high
busy  output  1  high while a frame is in progress or the FIFO is non-empty
overflow  output  1  sticky: digit_valid was high while digit_ready was low

Behaviour:
- Reset (resetn low, asynchronous) clears the FIFO, sets the FSM to IDLE, clears the baud and bit counters, and clears overflow. Outputs during reset: uarttx=1, busy=0, digit_ready=1.
- Reset mid-frame aborts the frame immediately; uarttx returns to 1 with no partial stop bit.
- Handshake: a transfer occurs on a rising edge where digit_valid && digit_ready.
  - digit_ready = !fifo_full, where fullness is taken from the count before this cycle's pop.
  - A push and a pop in the same cycle when full is not allowed; the push is refused.
  - A push and a pop in the same cycle when not full are both performed; count is unchanged.
- overflow sets on any edge with digit_valid && !digit_ready. It clears only on reset.
- Character mapping at pop:
  - 0-9 -> 0x30 + value.
  - 10-15 -> 0x2D ('-'), the error symbol.
- FSM states: IDLE, START, DATA, STOP, CR_PEND, LF_PEND.
  - IDLE: if the FIFO is non-empty, pop, load the shift register with the mapped character, go to START.
  - START: uarttx=0 for BAUD_DIV clocks -> DATA.
  - DATA: 8 bits, LSB first, each held BAUD_DIV clocks; a 3-bit counter runs 0..7 -> STOP.
  - STOP: uarttx=1 for BAUD_DIV clocks. Then:
    - if APPEND_CRLF and the frame was a digit -> load 0x0D, go to START, and mark the next frame as CR;
    - if the frame was CR -> load 0x0A, go to START, and mark it as LF;
    - otherwise -> IDLE.
  - CR_PEND and LF_PEND are encodings of that frame-kind tag. They may be implemented as a 2-bit tag instead of separate states, provided the waveform is identical.
- Frame length: exactly 10*BAUD_DIV clocks. Frames within one digit's sequence are back-to-back with no idle gap.
- Latency: the accept edge writes the FIFO. IDLE sees non-empty and pops on the following edge, and uarttx falls on that same edge. So the start bit begins 2 clocks after the accept edge when the block is idle.
- After STOP returns to IDLE, at least 1 clock of idle high occurs before the next start bit. This is the IDLE evaluation cycle.
- Baud counter: counts 0..BAUD_DIV-1 within each bit and wraps to 0 at a bit boundary.
- FIFO pointers: log2(FIFO_DEPTH) bits with a wrap bit; they wrap naturally at depth.
- busy = (state != IDLE) || !fifo_empty. busy goes high the edge after an accept and stays low only when fully drained.
- digit_in is sampled only at the accept edge; later changes have no effect.

Test Plan:
- Idle/reset (bench uses BAUD_DIV=4): hold resetn low then release -> uarttx=1, busy=0, digit_ready=1, overflow=0. No edges on uarttx for 100 clocks.
- Single digit, APPEND_CRLF=0: push 7 -> start bit begins 2 clocks after the accept edge. Line decodes to 0x37: bits 1,1,1,0,1,1,0,0 LSB first, 4 clocks each. Stop high; busy falls 40 clocks after the start bit began.
- CRLF sequence, APPEND_CRLF=1: push 3 -> three back-to-back frames 0x33, 0x0D, 0x0A, 120 clocks total. Then idle.
- Error mapping: push 12 -> frame 0x2D. Push 15 -> frame 0x2D.
- FIFO full and overflow: hold digit_valid high with 1,2,3,4,5,6 on consecutive clocks while the first frame runs (FIFO_DEPTH=4).
  - The 1st digit is popped immediately, so 1 through 5 are accepted; digit_ready drops once 2,3,4,5 fill the FIFO.
  - 6 is refused and overflow=1.
  - Transmitted order is 1,2,3,4,5; 6 is never sent.
  - overflow stays 1 until reset.
- Reset mid-frame: assert resetn low during bit 3 of a data frame -> uarttx=1 within the same cycle (asynchronous). After release, FIFO empty, busy=0, and no residual frame is sent.

Source files
------------

// File: rtl/uart_digit_tx_if.sv
// Digit handshake and UART status bundle for uart_digit_tx.
// The master drives digits; the slave (the transmitter) returns ready, line and status.
interface uart_digit_tx_if;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic       uarttx;
  logic       busy;
  logic       overflow;

  modport master (
    output digit_in, digit_valid,
    input  digit_ready, uarttx, busy, overflow
  );

  modport slave (
    input  digit_in, digit_valid,
    output digit_ready, uarttx, busy, overflow
  );
endinterface

// File: rtl/uart_digit_tx.sv
// Buffers decimal digits in a small FIFO and sends each as ASCII on an 8N1 UART line,
// optionally followed by CR LF.
module uart_digit_tx #(
  parameter int unsigned BAUD_DIV    = 1250,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          APPEND_CRLF = 1'b1
) (
  input  logic           clk,
  input  logic           resetn,
  uart_digit_tx_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  typedef enum logic [1:0] {KIND_DIGIT, KIND_CR, KIND_LF} kind_e;

  state_e         state_q, state_d;
  kind_e          kind_q, kind_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           ovf_q, ovf_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic [AW:0]    wr_q, wr_d, rd_q, rd_d, cnt_d;
  logic [3:0]     mem_q [FIFO_DEPTH];
  logic           push, pop, full, empty, bit_end;

  function automatic logic [7:0] to_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : 8'h2D;
  endfunction

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty   = (wr_q == rd_q);
  assign push    = bus.digit_valid && !full;
  assign bit_end = (baud_q == BW'(BAUD_DIV - 1));

  // Digit storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= bus.digit_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      kind_q  <= KIND_DIGIT;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Frame sequencer: the line level is registered alongside the state it belongs to
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + BW'(1);

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = to_ascii(mem_q[rd_q[AW-1:0]]);
          kind_d  = KIND_DIGIT;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (APPEND_CRLF && kind_q == KIND_DIGIT) begin
            shift_d = 8'h0D;
            kind_d  = KIND_CR;
            tx_d    = 1'b0;
            state_d = START;
          end else if (kind_q == KIND_CR) begin
            shift_d = 8'h0A;
            kind_d  = KIND_LF;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    wr_d    = wr_q + (AW+1)'(push);
    rd_d    = rd_q + (AW+1)'(pop);
    cnt_d   = wr_d - rd_d;
    ready_d = (cnt_d != (AW+1)'(FIFO_DEPTH));
    busy_d  = (state_d != IDLE) || (cnt_d != '0);
    ovf_d   = ovf_q || (bus.digit_valid && full);
  end

  assign bus.uarttx      = tx_q;
  assign bus.digit_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.overflow    = ovf_q;
endmodule
